// File: rtl/hamming_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_decoder
//  Description : Two-stage SEC-DED Hamming decoder with valid/ready handshakes
//                on both sides and saturating corrected/uncorrectable counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_decoder #(
    parameter int K     = 8,
    parameter int CNT_W = 16,
    // Fixed-point iteration of m = clog2(K+1+m); settles to the smallest m
    // with 2^m >= m+K+1 for every practical K.
    localparam int M    = $clog2(K + 1 + $clog2(K + 1 + $clog2(K + 1))),
    localparam int N    = M + K
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [N:0]       q_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [K-1:0]     d_o,
    output logic [M-1:0]     syndrome_o,
    output logic             err_single_o,
    output logic             err_double_o,
    output logic [CNT_W-1:0] corr_cnt_o,
    output logic [CNT_W-1:0] uncorr_cnt_o,
    input  logic             clr_cnt_i
);

    localparam logic [M-1:0]     c_n_syn   = M'(N);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Hamming position (1..N) of data bit j: the j-th non-power-of-two index.
    function automatic int data_pos(input int j);
        int cnt;
        data_pos = 0;
        cnt      = 0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == j) data_pos = i;
                cnt++;
            end
        end
    endfunction

    logic             r_s1_valid;
    logic [K-1:0]     r_s1_data;
    logic [M-1:0]     r_s1_syn;
    logic             r_s1_par;

    logic             r_valid;
    logic [K-1:0]     r_d;
    logic [M-1:0]     r_syn;
    logic             r_err_single;
    logic             r_err_double;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_out_hs;
    logic [M-1:0]     w_syn_in;
    logic             w_par_in;
    logic [K-1:0]     w_raw_data;
    logic [K-1:0]     w_data;
    logic             w_in_range;
    logic             w_flip;
    logic             w_single;
    logic             w_double;

    assign w_s2_load = !r_valid || ready_i;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_out_hs  = r_valid && ready_i;
    assign ready_o   = w_s1_load;

    always_comb begin
        w_syn_in = '0;
        for (int i = 1; i <= N; i++) begin
            if (q_i[i]) w_syn_in = w_syn_in ^ M'(i);
        end
    end

    assign w_par_in = ^q_i;

    // A syndrome beyond N cannot name a real bit, so it marks a multi-bit error.
    assign w_in_range = (r_s1_syn <= c_n_syn);
    assign w_flip     = r_s1_par && (r_s1_syn != '0) && w_in_range;
    assign w_single   = r_s1_par && w_in_range;
    assign w_double   = (!r_s1_par && (r_s1_syn != '0)) || (r_s1_par && !w_in_range);

    for (genvar j = 0; j < K; j++) begin : g_extract
        localparam int          c_pos     = data_pos(j);
        localparam logic [M-1:0] c_pos_syn = M'(c_pos);
        assign w_raw_data[j] = q_i[c_pos];
        assign w_data[j]     = r_s1_data[j] ^ (w_flip && (r_s1_syn == c_pos_syn));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_syn     <= '0;
            r_s1_par     <= 1'b0;
            r_valid      <= 1'b0;
            r_d          <= '0;
            r_syn        <= '0;
            r_err_single <= 1'b0;
            r_err_double <= 1'b0;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= valid_i;
                if (valid_i) begin
                    r_s1_data <= w_raw_data;
                    r_s1_syn  <= w_syn_in;
                    r_s1_par  <= w_par_in;
                end
            end

            if (w_s2_load) begin
                r_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_d          <= w_data;
                    r_syn        <= r_s1_syn;
                    r_err_single <= w_single;
                    r_err_double <= w_double;
                end
            end

            // Clear wins over a same-cycle increment.
            if (clr_cnt_i) begin
                r_corr_cnt   <= '0;
                r_uncorr_cnt <= '0;
            end else if (w_out_hs) begin
                if (r_err_single && (r_corr_cnt != c_cnt_max))
                    r_corr_cnt <= r_corr_cnt + CNT_W'(1);
                if (r_err_double && (r_uncorr_cnt != c_cnt_max))
                    r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
            end
        end
    end

    assign valid_o      = r_valid;
    assign d_o          = r_d;
    assign syndrome_o   = r_syn;
    assign err_single_o = r_err_single;
    assign err_double_o = r_err_double;
    assign corr_cnt_o   = r_corr_cnt;
    assign uncorr_cnt_o = r_uncorr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hamming_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_decoder
//  Description : Self-checking bench for hamming_decoder (vectors + random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_decoder;

    localparam int K = 8;
    localparam int M = 4;
    localparam int N = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i, valid_i, ready_i, clr_cnt_i;
    logic [N:0]     q_i;
    logic           ready_o, valid_o, err_single_o, err_double_o;
    logic [K-1:0]   d_o;
    logic [M-1:0]   syndrome_o;
    logic [15:0]    corr_cnt_o, uncorr_cnt_o;
    logic           s_ready_o, s_valid_o, s_single, s_double;
    logic [K-1:0]   s_d;
    logic [M-1:0]   s_syn;
    logic [1:0]     s_corr, s_unc;

    hamming_decoder #(.K(K), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .q_i(q_i), .valid_o(valid_o), .ready_i(ready_i), .d_o(d_o),
        .syndrome_o(syndrome_o), .err_single_o(err_single_o),
        .err_double_o(err_double_o), .corr_cnt_o(corr_cnt_o),
        .uncorr_cnt_o(uncorr_cnt_o), .clr_cnt_i(clr_cnt_i)
    );

    // Narrow-counter instance sharing all stimulus, used for saturation.
    hamming_decoder #(.K(K), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(s_ready_o),
        .q_i(q_i), .valid_o(s_valid_o), .ready_i(ready_i), .d_o(s_d),
        .syndrome_o(s_syn), .err_single_o(s_single),
        .err_double_o(s_double), .corr_cnt_o(s_corr),
        .uncorr_cnt_o(s_unc), .clr_cnt_i(clr_cnt_i)
    );

    typedef struct packed {
        logic [K-1:0] d;
        logic [M-1:0] syn;
        logic         sgl;
        logic         dbl;
    } res_t;

    typedef struct {
        logic [N:0]   q;
        logic [K-1:0] d;
        logic [M-1:0] syn;
        logic         sgl;
        logic         dbl;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   m_corr   = 0;
    int   m_unc    = 0;
    logic last_in_hs = 1'b0;
    res_t sb[$];

    function automatic logic [N:0] encode(input logic [K-1:0] d);
        logic [N:0] q;
        int j, s;
        q = '0; j = 0; s = 0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                q[i] = d[j];
                if (d[j]) s = s ^ i;
                j++;
            end
        end
        for (int k = 0; k < M; k++) if (s[k]) q[1 << k] = 1'b1;
        q[0] = ^q[N:1];
        return q;
    endfunction

    function automatic res_t ref_decode(input logic [N:0] q);
        res_t r;
        int s, j;
        logic p;
        logic [N:0] c;
        s = 0;
        for (int i = 1; i <= N; i++) if (q[i]) s = s ^ i;
        p = ^q;
        c = q;
        r = '0;
        if (s == 0)                r.sgl = p;
        else if (p && s <= N) begin c[s] = ~c[s]; r.sgl = 1'b1; end
        else                       r.dbl = 1'b1;
        j = 0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin r.d[j] = c[i]; j++; end
        end
        r.syn = s[M-1:0];
        return r;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: check at negedge, update the model at posedge, return at +1.
    task automatic step();
        logic in_hs, out_hs;
        res_t e;
        @(negedge clk);
        in_hs  = valid_i && ready_o && !rst_i;
        out_hs = valid_o && ready_i;
        chk("flags_exclusive", {31'b0, err_single_o & err_double_o}, 32'd0);
        chk("corr_cnt", {16'b0, corr_cnt_o}, sat(m_corr, 65535));
        chk("uncorr_cnt", {16'b0, uncorr_cnt_o}, sat(m_unc, 65535));
        chk("corr_cnt_w2", {30'b0, s_corr}, sat(m_corr, 3));
        chk("uncorr_cnt_w2", {30'b0, s_unc}, sat(m_unc, 3));
        if (out_hs) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {31'b0, valid_o}, 32'd0);
            end else begin
                e = sb[0];
                chk("d_o", {24'b0, d_o}, {24'b0, e.d});
                chk("syndrome_o", {28'b0, syndrome_o}, {28'b0, e.syn});
                chk("err_single_o", {31'b0, err_single_o}, {31'b0, e.sgl});
                chk("err_double_o", {31'b0, err_double_o}, {31'b0, e.dbl});
            end
        end
        @(posedge clk);
        if (rst_i) begin
            sb.delete();
            m_corr = 0;
            m_unc  = 0;
        end else begin
            if (out_hs) begin
                n_out++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    m_corr += int'(e.sgl);
                    m_unc  += int'(e.dbl);
                end
            end
            if (clr_cnt_i) begin m_corr = 0; m_unc = 0; end
            if (in_hs) sb.push_back(ref_decode(q_i));
        end
        last_in_hs = in_hs;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tab[8];
        int   idx, base;
        logic [N:0] q;

        tab = '{
            '{13'h05A,  8'h05, 4'd0,  1'b0, 1'b0},
            '{13'h01A,  8'h05, 4'd6,  1'b1, 1'b0},
            '{13'h05B,  8'h05, 4'd0,  1'b1, 1'b0},
            '{13'h012,  8'h00, 4'd5,  1'b0, 1'b1},
            '{13'h148,  8'h05, 4'd13, 1'b0, 1'b1},
            '{13'h105A, 8'h05, 4'd12, 1'b1, 1'b0},
            '{13'h15A,  8'h05, 4'd8,  1'b1, 1'b0},
            '{13'h000,  8'h00, 4'd0,  1'b0, 1'b0}
        };

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; clr_cnt_i = 1'b0; q_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
        chk("rst_d_o", {24'b0, d_o}, 32'd0);
        chk("rst_syndrome_o", {28'b0, syndrome_o}, 32'd0);
        chk("rst_err_single", {31'b0, err_single_o}, 32'd0);
        chk("rst_err_double", {31'b0, err_double_o}, 32'd0);
        chk("rst_corr_cnt", {16'b0, corr_cnt_o}, 32'd0);
        chk("rst_uncorr_cnt", {16'b0, uncorr_cnt_o}, 32'd0);
        chk("rst_ready_o", {31'b0, ready_o}, 32'd1);

        // Directed vectors with latency check.
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1; q_i = tab[i].q;
            step();
            valid_i = 1'b0;
            chk("lat_s1_only", {31'b0, valid_o}, 32'd0);
            step();
            chk("lat_valid", {31'b0, valid_o}, 32'd1);
            chk("vec_d", {24'b0, d_o}, {24'b0, tab[i].d});
            chk("vec_syn", {28'b0, syndrome_o}, {28'b0, tab[i].syn});
            chk("vec_single", {31'b0, err_single_o}, {31'b0, tab[i].sgl});
            chk("vec_double", {31'b0, err_double_o}, {31'b0, tab[i].dbl});
            step();
        end
        chk("table_corr_cnt", {16'b0, corr_cnt_o}, 32'd4);
        chk("table_uncorr_cnt", {16'b0, uncorr_cnt_o}, 32'd2);

        // Backpressure: four clean words against a stalled sink.
        ready_i = 1'b0; idx = 0; base = n_out;
        for (int c = 0; c < 4; c++) begin
            valid_i = (idx < 4); q_i = encode(8'(idx));
            step();
            if (last_in_hs) idx++;
        end
        chk("bp_accepts", idx, 32'd2);
        chk("bp_ready_low", {31'b0, ready_o}, 32'd0);
        ready_i = 1'b1;
        #1 chk("bp_ready_rise", {31'b0, ready_o}, 32'd1);
        for (int c = 0; c < 12; c++) begin
            valid_i = (idx < 4); q_i = encode(8'(idx));
            step();
            if (last_in_hs) idx++;
        end
        valid_i = 1'b0;
        chk("bp_delivered", n_out - base, 32'd4);

        // Saturation of the 2-bit counters.
        clr_cnt_i = 1'b1; step(); clr_cnt_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            valid_i = 1'b1;
            q_i = encode(8'(8'hA0 + k)) ^ (13'd1 << (k + 1));
            step();
        end
        valid_i = 1'b0;
        repeat (3) step();
        chk("sat_corr_w2", {30'b0, s_corr}, 32'd3);
        chk("sat_corr_w16", {16'b0, corr_cnt_o}, 32'd5);

        // Clear in the same cycle as an erroneous output handshake.
        valid_i = 1'b1; q_i = encode(8'h3C) ^ 13'h020;
        step();
        valid_i = 1'b0;
        step();
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        chk("clr_priority_w16", {16'b0, corr_cnt_o}, 32'd0);
        chk("clr_priority_w2", {30'b0, s_corr}, 32'd0);

        // Reset with both stages full.
        valid_i = 1'b1; q_i = 13'h012;
        step();
        valid_i = 1'b0;
        repeat (3) step();
        ready_i = 1'b0; valid_i = 1'b1;
        q_i = encode(8'h55); step();
        q_i = encode(8'hAA); step();
        chk("pre_reset_full", {31'b0, ready_o}, 32'd0);
        rst_i = 1'b1; valid_i = 1'b0;
        step();
        rst_i = 1'b0;
        chk("mid_rst_valid_o", {31'b0, valid_o}, 32'd0);
        chk("mid_rst_corr", {16'b0, corr_cnt_o}, 32'd0);
        chk("mid_rst_uncorr", {16'b0, uncorr_cnt_o}, 32'd0);
        chk("mid_rst_ready_o", {31'b0, ready_o}, 32'd1);
        ready_i = 1'b1; base = n_out;
        repeat (5) step();
        chk("no_stale_word", n_out - base, 32'd0);

        // Randomized traffic with 0..3 injected bit flips per word.
        for (int c = 0; c < 400; c++) begin
            valid_i   = ($urandom_range(0, 3) != 0);
            ready_i   = ($urandom_range(0, 3) != 0);
            clr_cnt_i = ($urandom_range(0, 49) == 0);
            q = encode(8'($urandom));
            for (int e = $urandom_range(0, 3); e > 0; e--)
                q[$urandom_range(0, N)] ^= 1'b1;
            q_i = q;
            step();
        end
        valid_i = 1'b0; ready_i = 1'b1; clr_cnt_i = 1'b0;
        repeat (4) step();
        chk("drain_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
